rename_map_ckpt: RTL and testbench

RENAME_MAP_CKPT -- requirements
Module: rename_map_ckpt

---
 rtl/rename_map_ckpt_pkg.sv | 19 +
 rtl/rename_map_hit_enc.sv | 29 ++
 rtl/rename_map_ckpt.sv | 139 +++++++++++++
 tb/tb_rename_map_ckpt.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rename_map_ckpt_pkg.sv
// Shared defaults and control encodings for the rename map CAM with valid-vector checkpoints.
package rename_map_ckpt_pkg;

  localparam int DEF_DATA  = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_WRITE = 2;
  localparam int DEF_READ  = 2;
  localparam int DEF_CKPT  = 4;

  // All enables, resets and strobes on this block are active-low.
  localparam logic EN_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    VSRC_WRITE   = 2'd0,
    VSRC_RESTORE = 2'd1,
    VSRC_FLUSH   = 2'd2
  } vsrc_e;

endpackage

// File: rtl/rename_map_hit_enc.sv
// Reduces one lookup port's hit vector to match, multi-hit and lowest hitting index.
module rename_map_hit_enc
  import rename_map_ckpt_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             en,
  input  logic [DEPTH-1:0] hit,
  output logic             match,
  output logic             multi,
  output logic [ADDR-1:0]  raddr
);

  always_comb begin
    match = 1'b0;
    multi = 1'b0;
    raddr = '0;
    if (en) begin
      match = |hit;
      // Clearing the lowest set bit leaves something only if two or more bits were set.
      multi = |(hit & (hit - DEPTH'(1)));
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (hit[i]) raddr = ADDR'(i);
      end
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register-rename CAM: multi-port masked writes, masked lookups, valid-vector checkpoint/restore/flush.
// Define RENAME_MAP_BYPASS_EN to let lookups see same-cycle writes.
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
#(
  parameter int DATA  = DEF_DATA,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WRITE = DEF_WRITE,
  parameter int READ  = DEF_READ,
  parameter int CKPT  = DEF_CKPT,
  localparam int ADDR  = $clog2(DEPTH),
  localparam int CADDR = $clog2(CKPT)
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [WRITE-1:0]      we_,
  input  logic [ADDR*WRITE-1:0] waddr,
  input  logic [DATA*WRITE-1:0] wd,
  input  logic [DATA*WRITE-1:0] wm,
  input  logic [WRITE-1:0]      wv,
  input  logic [READ-1:0]       re_,
  input  logic [DATA*READ-1:0]  rd,
  input  logic [DATA*READ-1:0]  rm,
  output logic [READ-1:0]       match,
  output logic [READ-1:0]       multi,
  output logic [ADDR*READ-1:0]  raddr,
  input  logic                  ckpt_we_,
  input  logic [CADDR-1:0]      ckpt_id,
  input  logic                  restore_,
  input  logic [CADDR-1:0]      restore_id,
  input  logic                  flush_,
  output logic [ADDR:0]         valid_cnt
);

  logic [DATA-1:0]  data_reg  [DEPTH];
  logic [DATA-1:0]  data_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_wr;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] ckpt_reg  [CKPT];
  logic [DEPTH-1:0] ckpt_next [CKPT];
  logic [ADDR:0]    valid_cnt_reg;
  logic [ADDR:0]    cnt_next;
  vsrc_e            vsrc;

  // Ports applied in ascending order so the higher index lands last and wins.
  always_comb begin
    data_next = data_reg;
    valid_wr  = valid_reg;
    for (int w = 0; w < WRITE; w++) begin
      if (we_[w] == EN_ACTIVE) begin
        data_next[waddr[w*ADDR +: ADDR]] = (data_next[waddr[w*ADDR +: ADDR]] & wm[w*DATA +: DATA])
                                         | (wd[w*DATA +: DATA] & ~wm[w*DATA +: DATA]);
        valid_wr[waddr[w*ADDR +: ADDR]]  = wv[w];
      end
    end
  end

  always_comb begin
    vsrc = VSRC_WRITE;
    if (flush_ == EN_ACTIVE)        vsrc = VSRC_FLUSH;
    else if (restore_ == EN_ACTIVE) vsrc = VSRC_RESTORE;

    case (vsrc)
      VSRC_FLUSH:   valid_next = '0;
      VSRC_RESTORE: valid_next = ckpt_reg[restore_id];
      default:      valid_next = valid_wr;
    endcase

    // Snapshot takes the final next-state vector, so a restore in the same cycle is captured.
    ckpt_next = ckpt_reg;
    if (vsrc == VSRC_FLUSH) begin
      for (int k = 0; k < CKPT; k++) ckpt_next[k] = '0;
    end else if (ckpt_we_ == EN_ACTIVE) begin
      ckpt_next[ckpt_id] = valid_next;
    end

    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) cnt_next = cnt_next + {{ADDR{1'b0}}, valid_next[i]};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) data_reg[i] <= '0;
      for (int k = 0; k < CKPT; k++)  ckpt_reg[k] <= '0;
      valid_reg     <= '0;
      valid_cnt_reg <= '0;
    end else begin
      data_reg      <= data_next;
      ckpt_reg      <= ckpt_next;
      valid_reg     <= valid_next;
      valid_cnt_reg <= cnt_next;
    end
  end

  assign valid_cnt = valid_cnt_reg;

  logic [DATA-1:0]  look_data [DEPTH];
  logic [DEPTH-1:0] look_valid;

`ifdef RENAME_MAP_BYPASS_EN
  always_comb begin
    look_data  = data_next;
    look_valid = valid_wr;
  end
`else
  always_comb begin
    look_data  = data_reg;
    look_valid = valid_reg;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < READ; gi++) begin : g_look
      logic [DEPTH-1:0] hit;

      always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
          hit[e] = look_valid[e]
                && (((look_data[e] ^ rd[gi*DATA +: DATA]) & ~rm[gi*DATA +: DATA]) == '0);
        end
      end

      // Gating on reset_ keeps bypassed writes from producing hits while in reset.
      rename_map_hit_enc #(
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
      ) u_hit_enc (
        .en    ((re_[gi] == EN_ACTIVE) && reset_),
        .hit   (hit),
        .match (match[gi]),
        .multi (multi[gi]),
        .raddr (raddr[gi*ADDR +: ADDR])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed table-driven bench for rename_map_ckpt at DATA=8 DEPTH=16 WRITE=2 READ=2 CKPT=4.
module tb_rename_map_ckpt;

  logic       clk = 1'b0;
  logic       reset_;
  logic [1:0] we_;
  logic [7:0] waddr;
  logic [15:0] wd, wm;
  logic [1:0] wv;
  logic [1:0] re_;
  logic [15:0] rd, rm;
  logic [1:0] match, multi;
  logic [7:0] raddr;
  logic       ckpt_we_, restore_, flush_;
  logic [1:0] ckpt_id, restore_id;
  logic [4:0] valid_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_map_ckpt #(.DATA(8), .DEPTH(16), .WRITE(2), .READ(2), .CKPT(4)) dut (
    .clk(clk), .reset_(reset_),
    .we_(we_), .waddr(waddr), .wd(wd), .wm(wm), .wv(wv),
    .re_(re_), .rd(rd), .rm(rm),
    .match(match), .multi(multi), .raddr(raddr),
    .ckpt_we_(ckpt_we_), .ckpt_id(ckpt_id),
    .restore_(restore_), .restore_id(restore_id),
    .flush_(flush_), .valid_cnt(valid_cnt)
  );

  typedef struct packed {
    logic [1:0]      we_;
    logic [1:0][3:0] wa;
    logic [1:0][7:0] wd;
    logic [1:0][7:0] wm;
    logic [1:0]      wv;
    logic            ck_;
    logic [1:0]      ck_id;
    logic            rs_;
    logic [1:0]      rs_id;
    logic            fl_;
    logic [1:0]      re_;
    logic [1:0][7:0] rd;
    logic [1:0][7:0] rm;
    logic [1:0]      em;
    logic [1:0]      emu;
    logic [1:0][3:0] ea;
    logic [4:0]      ecnt;
  } vec_t;

  vec_t vecs[$];
  vec_t c;

  task automatic nv();
    c = '0;
    c.we_ = 2'b11; c.ck_ = 1'b1; c.rs_ = 1'b1; c.fl_ = 1'b1; c.re_ = 2'b11;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d, input logic [7:0] m, input logic v);
    c.we_[p] = 1'b0; c.wa[p] = a; c.wd[p] = d; c.wm[p] = m; c.wv[p] = v;
  endtask

  task automatic lk(input int p, input logic [7:0] d, input logic [7:0] m,
                    input logic hit, input logic mul, input logic [3:0] a);
    c.re_[p] = 1'b0; c.rd[p] = d; c.rm[p] = m; c.em[p] = hit; c.emu[p] = mul; c.ea[p] = a;
  endtask

  task automatic push(input logic [4:0] cnt);
    c.ecnt = cnt;
    vecs.push_back(c);
    nv();
  endtask

  task automatic drive(input vec_t v);
    we_ = v.we_; waddr = v.wa; wd = v.wd; wm = v.wm; wv = v.wv;
    ckpt_we_ = v.ck_; ckpt_id = v.ck_id; restore_ = v.rs_; restore_id = v.rs_id; flush_ = v.fl_;
    re_ = v.re_; rd = v.rd; rm = v.rm;
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input vec_t v);
    chk("match0", row, {7'd0, match[0]}, {7'd0, v.em[0]});
    chk("multi0", row, {7'd0, multi[0]}, {7'd0, v.emu[0]});
    chk("raddr0", row, {4'd0, raddr[3:0]}, {4'd0, v.ea[0]});
    chk("match1", row, {7'd0, match[1]}, {7'd0, v.em[1]});
    chk("multi1", row, {7'd0, multi[1]}, {7'd0, v.emu[1]});
    chk("raddr1", row, {4'd0, raddr[7:4]}, {4'd0, v.ea[1]});
    chk("valid_cnt", row, {3'd0, valid_cnt}, {3'd0, v.ecnt});
    $display("row %0d: match=%b multi=%b raddr=%h valid_cnt=%0d", row, match, multi, raddr, valid_cnt);
  endtask

  initial begin
    nv();
    // Row 0: nothing valid after reset
    lk(0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0); lk(1, 8'h00, 8'hFF, 1'b0, 1'b0, 4'd0); push(5'd0);
    // Rows 1-2: distinct writes, hit and miss
    wr(0, 4'd0, 8'h00, 8'h00, 1'b1); wr(1, 4'd2, 8'h01, 8'h00, 1'b1); push(5'd0);
    lk(0, 8'h01, 8'h00, 1'b1, 1'b0, 4'd2); lk(1, 8'h04, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd2);
    // Rows 3-4: duplicate tag -> multi, lowest index
    wr(0, 4'd3, 8'h05, 8'h00, 1'b1); wr(1, 4'd7, 8'h05, 8'h00, 1'b1); push(5'd2);
    lk(0, 8'h05, 8'h00, 1'b1, 1'b1, 4'd3); lk(1, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0); push(5'd4);
    // Rows 5-6: same-entry collision, port 1 wins
    wr(0, 4'd4, 8'h10, 8'h00, 1'b1); wr(1, 4'd4, 8'h20, 8'h00, 1'b1); push(5'd4);
    lk(0, 8'h20, 8'h00, 1'b1, 1'b0, 4'd4); lk(1, 8'h10, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd5);
    // Rows 7-8: invalidate 3,7,4 keeping data
    wr(0, 4'd3, 8'h00, 8'hFF, 1'b0); wr(1, 4'd7, 8'h00, 8'hFF, 1'b0); push(5'd5);
    wr(0, 4'd4, 8'h00, 8'hFF, 1'b0); lk(1, 8'h05, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd3);
    // Row 9: snapshot {0,2} to slot 1; masked lookup ignoring bit 0
    c.ck_ = 1'b0; c.ck_id = 2'd1; lk(0, 8'h00, 8'h01, 1'b1, 1'b1, 4'd0); push(5'd2);
    // Rows 10-12: write 0x09 then roll back
    wr(0, 4'd5, 8'h09, 8'h00, 1'b1); push(5'd2);
    c.rs_ = 1'b0; c.rs_id = 2'd1; lk(0, 8'h09, 8'h00, 1'b1, 1'b0, 4'd5); push(5'd3);
    lk(0, 8'h09, 8'h00, 1'b0, 1'b0, 4'd0); lk(1, 8'h01, 8'h00, 1'b1, 1'b0, 4'd2); push(5'd2);
    // Row 13: restore with a write: data lands, valid ignored
    c.rs_ = 1'b0; c.rs_id = 2'd1; wr(0, 4'd6, 8'h0A, 8'h00, 1'b1); push(5'd2);
    // Row 14: snapshot + restore together (restore empty slot 0 into slot 2)
    c.ck_ = 1'b0; c.ck_id = 2'd2; c.rs_ = 1'b0; c.rs_id = 2'd0;
    lk(0, 8'h0A, 8'h00, 1'b0, 1'b0, 4'd0); lk(1, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0); push(5'd2);
    // Rows 15-16: revalidate entry 6 keeping data written under restore
    wr(0, 4'd6, 8'h00, 8'hFF, 1'b1); push(5'd0);
    c.rs_ = 1'b0; c.rs_id = 2'd1; lk(0, 8'h0A, 8'h00, 1'b1, 1'b0, 4'd6); push(5'd1);
    // Rows 17-18: flush with snapshot; slot 1 must be cleared too
    c.fl_ = 1'b0; c.ck_ = 1'b0; c.ck_id = 2'd3; lk(1, 8'h01, 8'h00, 1'b1, 1'b0, 4'd2); push(5'd2);
    c.rs_ = 1'b0; c.rs_id = 2'd1; lk(0, 8'h01, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd0);
    // Rows 19-21: slot 3 snapshot taken during flush stays cleared
    wr(0, 4'd2, 8'h00, 8'hFF, 1'b1); push(5'd0);
    c.rs_ = 1'b0; c.rs_id = 2'd3; lk(1, 8'h01, 8'h00, 1'b1, 1'b0, 4'd2); push(5'd1);
    lk(0, 8'h01, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd0);
    // Rows 22-23: same-cycle write and lookup
    wr(1, 4'd9, 8'h33, 8'h00, 1'b1);
`ifdef RENAME_MAP_BYPASS_EN
    lk(0, 8'h33, 8'h00, 1'b1, 1'b0, 4'd9);
`else
    lk(0, 8'h33, 8'h00, 1'b0, 1'b0, 4'd0);
`endif
    push(5'd0);
    lk(0, 8'h33, 8'h00, 1'b1, 1'b0, 4'd9); push(5'd1);
    // Rows 24-25: partial write, 0x33 with low nibble forced -> 0x3F
    wr(0, 4'd9, 8'hFF, 8'hF0, 1'b1); push(5'd1);
    lk(0, 8'h3F, 8'h00, 1'b1, 1'b0, 4'd9); lk(1, 8'h33, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd1);
    // Rows 26-27: flush beats a same-cycle valid write
    c.fl_ = 1'b0; wr(0, 4'd1, 8'h00, 8'h00, 1'b1); push(5'd1);
    lk(0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0); push(5'd0);

    reset_ = 1'b0;
    nv(); drive(c);
    repeat (2) @(negedge clk);
    #2;
    chk("reset_cnt", -1, {3'd0, valid_cnt}, 8'd0);
    chk("reset_match", -1, {6'd0, match}, 8'd0);
    reset_ = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk_all(i, vecs[i]);
    end

    // Async reset mid-cycle abandons a pending write and clears everything.
    @(negedge clk); nv(); wr(0, 4'd9, 8'h00, 8'hFF, 1'b1); drive(c);
    @(negedge clk); nv(); lk(0, 8'h3F, 8'h00, 1'b1, 1'b0, 4'd9); wr(1, 4'd8, 8'h3F, 8'h00, 1'b1); drive(c);
    #2;
    chk("pre_reset_match", 100, {7'd0, match[0]}, 8'd1);
    chk("pre_reset_cnt", 100, {3'd0, valid_cnt}, 8'd1);
    reset_ = 1'b0;
    #1;
    chk("async_reset_cnt", 101, {3'd0, valid_cnt}, 8'd0);
    chk("async_reset_match", 101, {6'd0, match}, 8'd0);
    @(negedge clk);
    chk("held_reset_match", 102, {6'd0, match}, 8'd0);
    reset_ = 1'b1;
    nv(); wr(0, 4'd9, 8'h00, 8'hFF, 1'b1); drive(c);
    @(negedge clk);
    nv(); lk(0, 8'h00, 8'h00, 1'b1, 1'b0, 4'd9); lk(1, 8'h3F, 8'h00, 1'b0, 1'b0, 4'd0); drive(c);
    #2;
    c.ecnt = 5'd1;
    chk_all(103, c);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
